// File: rtl/pong_pkg.sv
// Pong datapath shared defaults and the ball-period helper.
// Optional feature macro: PONG_HISCORE_EN (high-score register).
package pong_pkg;

    localparam int unsigned TICKS_PER_SEC_DEF = 100_000_000;
    localparam int unsigned SERVE_SEC_DEF     = 5;
    localparam int unsigned LEVEL_SEC_DEF     = 20;
    localparam int unsigned HIT_W_DEF         = 8;
    localparam int unsigned LVL_W_DEF         = 4;
    localparam int unsigned MAX_LEVEL_DEF     = 9;
    localparam int unsigned BASE_DIV_DEF      = 1_000_000;
    localparam int unsigned DIV_STEP_DEF      = 100_000;
    localparam int unsigned MIN_DIV_DEF       = 2;

    // Signed math so a large level never wraps below the floor.
    function automatic longint ball_period(
        input longint lvl,
        input longint base,
        input longint step,
        input longint floor_v
    );
        longint p;
        p = base - lvl * step;
        if (p < floor_v) p = floor_v;
        return p;
    endfunction

endpackage

// File: rtl/pong_sec_timer.sv
// Enable-driven interval counter: saturating with a done flag (WRAP=0)
// or wrapping with a one-cycle wrap pulse (WRAP=1).
module pong_sec_timer
    import pong_pkg::*;
#(
    parameter longint unsigned LIMIT = 10,
    parameter bit              WRAP  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic done_o,
    output logic wrap_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    generate
        if (WRAP) begin : g_wrap
            logic at_end;
            assign at_end = (cnt_q == CW'(LIMIT - 1));

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = at_end ? '0 : cnt_q + CW'(1);
                end
            end

            assign wrap_o = en_i && !clr_i && at_end;
            assign done_o = 1'b0;
        end else begin : g_hold
            logic done_q;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i && (cnt_q != CW'(LIMIT))) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    done_q <= 1'b0;
                end else begin
                    done_q <= (cnt_d == CW'(LIMIT));
                end
            end

            assign done_o = done_q;
            assign wrap_o = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_datapath.sv
// Pong game datapath: serve/level timers, level, ball tick, hit counter.
// Define PONG_HISCORE_EN to add the persistent high-score register.
module pong_datapath
    import pong_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int unsigned SERVE_SEC     = SERVE_SEC_DEF,
    parameter int unsigned LEVEL_SEC     = LEVEL_SEC_DEF,
    parameter int unsigned HIT_W         = HIT_W_DEF,
    parameter int unsigned LVL_W         = LVL_W_DEF,
    parameter int unsigned MAX_LEVEL     = MAX_LEVEL_DEF,
    parameter int unsigned BASE_DIV      = BASE_DIV_DEF,
    parameter int unsigned DIV_STEP      = DIV_STEP_DEF,
    parameter int unsigned MIN_DIV       = MIN_DIV_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             serve_en,
    input  logic             serve_rst,
    input  logic             level_en,
    input  logic             level_rst,
    input  logic             hit_ld,
    input  logic             hit_clr,
    input  logic             lvl_clr,
    output logic             serve_done,
    output logic             ball_tick,
    output logic [HIT_W-1:0] hit_cnt,
    output logic             hit_sat,
    output logic [LVL_W-1:0] lvl,
    output logic [HIT_W-1:0] hi_score
);

    localparam longint unsigned S_LIM =
        64'(SERVE_SEC) * 64'(TICKS_PER_SEC);
    localparam longint unsigned L_LIM =
        64'(LEVEL_SEC) * 64'(TICKS_PER_SEC);
    localparam int DIV_W = $clog2(BASE_DIV);

    logic             adv;
    logic             unused_serve_wrap;
    logic             unused_level_done;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;
    logic [LVL_W-1:0] lvl_q;
    logic [LVL_W-1:0] lvl_d;
    logic [HIT_W-1:0] hit_q;
    logic [HIT_W-1:0] hit_d;

    pong_sec_timer #(
        .LIMIT (S_LIM),
        .WRAP  (1'b0)
    ) u_serve (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .en_i   (serve_en),
        .clr_i  (serve_rst),
        .done_o (serve_done),
        .wrap_o (unused_serve_wrap)
    );

    pong_sec_timer #(
        .LIMIT (L_LIM),
        .WRAP  (1'b1)
    ) u_level (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .en_i   (level_en),
        .clr_i  (level_rst),
        .done_o (unused_level_done),
        .wrap_o (adv)
    );

    always_comb begin
        lvl_d = lvl_q;
        if (lvl_clr) begin
            lvl_d = '0;
        end else if (adv && (lvl_q < LVL_W'(MAX_LEVEL))) begin
            lvl_d = lvl_q + LVL_W'(1);
        end
    end

    // Tick is precomputed against next cycle's level so it stays registered.
    always_comb begin
        div_d  = tick_q ? '0 : div_q + DIV_W'(1);
        tick_d = longint'(div_d) >=
                 ball_period(longint'(lvl_d), longint'(BASE_DIV),
                             longint'(DIV_STEP), longint'(MIN_DIV)) - 1;
    end

    always_comb begin
        hit_d = hit_q;
        if (hit_clr) begin
            hit_d = '0;
        end else if (hit_ld && tick_q && !(&hit_q)) begin
            hit_d = hit_q + HIT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            lvl_q  <= '0;
            div_q  <= '0;
            tick_q <= 1'b0;
            hit_q  <= '0;
        end else begin
            lvl_q  <= lvl_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            hit_q  <= hit_d;
        end
    end

`ifdef PONG_HISCORE_EN
    logic [HIT_W-1:0] hi_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hi_q <= '0;
        end else if (hit_q > hi_q) begin
            hi_q <= hit_q;
        end
    end

    assign hi_score = hi_q;
`else
    assign hi_score = '0;
`endif

    assign ball_tick = tick_q;
    assign hit_cnt   = hit_q;
    assign hit_sat   = &hit_q;
    assign lvl       = lvl_q;

endmodule

// File: tb/tb_pong_datapath.sv
// Directed self-checking bench for pong_datapath (small timing params).
// Hi-score expectations follow PONG_HISCORE_EN when it is defined.
module tb_pong_datapath;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       serve_en, serve_rst, level_en, level_rst;
    logic       hit_ld, hit_clr, lvl_clr;
    logic       serve_done, ball_tick, hit_sat;
    logic [3:0] hit_cnt, lvl, hi_score;

    int vec = 0;
    int miss = 0;

`ifdef PONG_HISCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    pong_datapath #(
        .TICKS_PER_SEC (10),
        .SERVE_SEC     (5),
        .LEVEL_SEC     (2),
        .HIT_W         (4),
        .LVL_W         (4),
        .MAX_LEVEL     (9),
        .BASE_DIV      (8),
        .DIV_STEP      (1),
        .MIN_DIV       (3)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .serve_en   (serve_en),
        .serve_rst  (serve_rst),
        .level_en   (level_en),
        .level_rst  (level_rst),
        .hit_ld     (hit_ld),
        .hit_clr    (hit_clr),
        .lvl_clr    (lvl_clr),
        .serve_done (serve_done),
        .ball_tick  (ball_tick),
        .hit_cnt    (hit_cnt),
        .hit_sat    (hit_sat),
        .lvl        (lvl),
        .hi_score   (hi_score)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        serve_en = 0; serve_rst = 0; level_en = 0; level_rst = 0;
        hit_ld = 0; hit_clr = 0; lvl_clr = 0;
        cyc(2);
        Rst = 1'b0;
    endtask

    task automatic measure_period(output int p);
        int w;
        p = -1;
        w = 0;
        while (ball_tick !== 1'b1 && w < 40) begin
            cyc(1);
            w++;
        end
        if (ball_tick === 1'b1) begin
            w = 0;
            do begin
                cyc(1);
                w++;
            end while (ball_tick !== 1'b1 && w < 40);
            if (ball_tick === 1'b1) p = w;
        end
    endtask

    task automatic test_reset();
        int p;
        Rst = 1'b1;
        serve_en = 0; serve_rst = 0; level_en = 0; level_rst = 0;
        hit_ld = 0; hit_clr = 0; lvl_clr = 0;
        cyc(3);
        vec++;
        if ({serve_done, ball_tick, hit_cnt, hit_sat, lvl, hi_score} !== 15'd0) begin
            miss++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {serve_done, ball_tick, hit_cnt, hit_sat, lvl, hi_score});
        end
        Rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            cyc(1);
            vec++;
            if (ball_tick !== (n == 7)) begin
                miss++;
                $display("FAIL first_tick[%0d]: got %b expected %b", n, ball_tick, n == 7);
            end
        end
        for (int k = 0; k < 2; k++) begin
            measure_period(p);
            vec++;
            if (p !== 8) begin
                miss++;
                $display("FAIL period_lvl0: got %0d expected 8", p);
            end
        end
    endtask

    task automatic test_serve();
        do_reset();
        serve_en = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            cyc(1);
            vec++;
            if (serve_done !== (n == 50)) begin
                miss++;
                $display("FAIL serve_rise[%0d]: got %b expected %b", n, serve_done, n == 50);
            end
        end
        serve_en = 1'b0;
        cyc(5);
        vec++;
        if (serve_done !== 1'b1) begin
            miss++;
            $display("FAIL serve_hold: got %b expected 1", serve_done);
        end
        serve_rst = 1'b1;
        cyc(1);
        serve_rst = 1'b0;
        vec++;
        if (serve_done !== 1'b0) begin
            miss++;
            $display("FAIL serve_clear: got %b expected 0", serve_done);
        end
        serve_en = 1'b1;
        serve_rst = 1'b1;
        cyc(60);
        vec++;
        if (serve_done !== 1'b0) begin
            miss++;
            $display("FAIL serve_rst_beats_en: got %b expected 0", serve_done);
        end
        serve_rst = 1'b0;
        cyc(49);
        vec++;
        if (serve_done !== 1'b0) begin
            miss++;
            $display("FAIL serve_recount49: got %b expected 0", serve_done);
        end
        cyc(1);
        vec++;
        if (serve_done !== 1'b1) begin
            miss++;
            $display("FAIL serve_recount50: got %b expected 1", serve_done);
        end
        serve_en = 1'b0;
    endtask

    task automatic test_level();
        int p;
        int e;
        do_reset();
        level_en = 1'b1;
        for (int n = 1; n <= 220; n++) begin
            cyc(1);
            e = (n / 20 > 9) ? 9 : n / 20;
            vec++;
            if (lvl !== 4'(e)) begin
                miss++;
                $display("FAIL level_step[%0d]: got %0d expected %0d", n, lvl, e);
            end
            if (n == 80) begin
                level_en = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    measure_period(p);
                    vec++;
                    if (p !== 4) begin
                        miss++;
                        $display("FAIL period_lvl4: got %0d expected 4", p);
                    end
                end
                level_en = 1'b1;
            end
        end
        level_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            measure_period(p);
            vec++;
            if (p !== 3) begin
                miss++;
                $display("FAIL period_floor: got %0d expected 3", p);
            end
        end
    endtask

    task automatic test_hit();
        int e;
        do_reset();
        hit_ld = 1'b1;
        for (int n = 1; n <= 140; n++) begin
            cyc(1);
            e = (n / 8 > 15) ? 15 : n / 8;
            vec++;
            if (hit_cnt !== 4'(e) || hit_sat !== (e == 15) || ball_tick !== (n % 8 == 7)) begin
                miss++;
                $display("FAIL hit_count[%0d]: got cnt=%0d sat=%b tick=%b expected cnt=%0d sat=%b tick=%b",
                         n, hit_cnt, hit_sat, ball_tick, e, e == 15, n % 8 == 7);
            end
        end
        hit_clr = 1'b1;
        cyc(1);
        hit_clr = 1'b0;
        hit_ld = 1'b0;
        vec++;
        if (hit_cnt !== 4'd0 || hit_sat !== 1'b0) begin
            miss++;
            $display("FAIL hit_clear: got cnt=%0d sat=%b expected 0 0", hit_cnt, hit_sat);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        level_en = 1'b1;
        cyc(59);
        vec++;
        if (lvl !== 4'd2) begin
            miss++;
            $display("FAIL adv_pre: got %0d expected 2", lvl);
        end
        lvl_clr = 1'b1;
        cyc(1);
        lvl_clr = 1'b0;
        vec++;
        if (lvl !== 4'd0) begin
            miss++;
            $display("FAIL lvl_clr_beats_adv: got %0d expected 0", lvl);
        end
        cyc(20);
        level_en = 1'b0;
        vec++;
        if (lvl !== 4'd1) begin
            miss++;
            $display("FAIL adv_after_clr: got %0d expected 1", lvl);
        end

        do_reset();
        hit_ld = 1'b1;
        cyc(15);
        vec++;
        if (hit_cnt !== 4'd1 || ball_tick !== 1'b1) begin
            miss++;
            $display("FAIL hitclr_pre: got cnt=%0d tick=%b expected 1 1", hit_cnt, ball_tick);
        end
        hit_clr = 1'b1;
        cyc(1);
        hit_clr = 1'b0;
        hit_ld = 1'b0;
        vec++;
        if (hit_cnt !== 4'd0) begin
            miss++;
            $display("FAIL hit_clr_beats_inc: got %0d expected 0", hit_cnt);
        end

        do_reset();
        serve_en = 1'b1;
        cyc(30);
        Rst = 1'b1;
        cyc(1);
        Rst = 1'b0;
        vec++;
        if (serve_done !== 1'b0) begin
            miss++;
            $display("FAIL rst_mid_serve: got %b expected 0", serve_done);
        end
        cyc(49);
        vec++;
        if (serve_done !== 1'b0) begin
            miss++;
            $display("FAIL serve_restart49: got %b expected 0", serve_done);
        end
        cyc(1);
        vec++;
        if (serve_done !== 1'b1) begin
            miss++;
            $display("FAIL serve_restart50: got %b expected 1", serve_done);
        end
        serve_en = 1'b0;
    endtask

    task automatic test_hiscore();
        logic [3:0] e7;
        e7 = HS ? 4'd7 : 4'd0;
        do_reset();
        hit_ld = 1'b1;
        cyc(56);
        hit_ld = 1'b0;
        cyc(2);
        vec++;
        if (hit_cnt !== 4'd7 || hi_score !== e7) begin
            miss++;
            $display("FAIL hiscore_7: got cnt=%0d hi=%0d expected 7 %0d", hit_cnt, hi_score, e7);
        end
        hit_clr = 1'b1;
        cyc(1);
        hit_clr = 1'b0;
        cyc(2);
        vec++;
        if (hit_cnt !== 4'd0 || hi_score !== e7) begin
            miss++;
            $display("FAIL hiscore_survive_clr: got cnt=%0d hi=%0d expected 0 %0d",
                     hit_cnt, hi_score, e7);
        end
        hit_ld = 1'b1;
        cyc(19);
        hit_ld = 1'b0;
        cyc(2);
        vec++;
        if (hit_cnt !== 4'd3 || hi_score !== e7) begin
            miss++;
            $display("FAIL hiscore_3: got cnt=%0d hi=%0d expected 3 %0d", hit_cnt, hi_score, e7);
        end
        Rst = 1'b1;
        cyc(1);
        Rst = 1'b0;
        vec++;
        if (hi_score !== 4'd0 || hit_cnt !== 4'd0) begin
            miss++;
            $display("FAIL hiscore_rst: got hi=%0d cnt=%0d expected 0 0", hi_score, hit_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_level();
        test_hit();
        test_simultaneous();
        test_hiscore();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
